bpsk_bit_modulator: RTL
=======================

Name: bpsk_bit_modulator

Overview:
Downstream datapath of the BPSK controller. It takes bytes from the data source, serialises them MSB-first and multiplies each sine-generator sample by +1 or -1 per bit. One bit spans SAMPLES_PER_BIT samples. It drives data_rdy back to the controller and consumes the controller's mod_en.

Parameters:
SAMPLE_W, 12, width of signed two's-complement sine and output samples
SAMPLES_PER_BIT, 16, sine samples per symbol (>=2)
CNT_W, 4, width of sample counter (>= clog2(SAMPLES_PER_BIT))

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
mod_en  in  1  from controller; 1 = modulation permitted
sine_valid  in  1  one-cycle strobe, new sine sample present
sine_in  in  SAMPLE_W  signed sine sample
byte_in  in  8  data byte from source
byte_valid  in  1  byte_in valid
byte_ready  out  1  holding register empty, byte accepted when byte_valid&byte_ready
data_rdy  out  1  shift register holds a byte being transmitted (to controller)
mod_out  out  SAMPLE_W  signed modulated sample
mod_valid  out  1  one-cycle strobe, mod_out updated
bit_out  out  1  current transmitted bit (debug/scope)
sym_start  out  1  one-cycle strobe with first sample of each bit
underrun  out  1  sticky: bit stream ran dry while mod_en=1

Behaviour:
- Reset: all outputs 0 except byte_ready=1. Hold and shift registers empty, counters 0. Reset mid-operation discards both buffered bytes.
- Storage: 1-byte holding register (hold, hold_full) plus 8-bit shift register (shreg, shreg_valid). Double buffering.
- byte_ready = ~hold_full, combinational. An accept sets hold_full on the next edge.
- Load: if shreg_valid=0 and hold_full=1, shreg<=hold, shreg_valid<=1, hold_full<=0, bit_cnt<=0, samp_cnt<=0. Independent of mod_en. Takes one cycle.
- data_rdy = shreg_valid (registered state).
- Modulate: occurs on a cycle with mod_en & sine_valid & shreg_valid.
  - Current bit b = shreg[7-bit_cnt].
  - Next edge: mod_out <= b ? sine_in : -sine_in; mod_valid<=1; bit_out<=b; sym_start<=(samp_cnt==0).
  - Latency is 1 cycle from the sine_valid strobe.
- Negation saturates: -(-2^(SAMPLE_W-1)) gives 2^(SAMPLE_W-1)-1.
- Counters:
  - samp_cnt increments per modulated sample.
  - At SAMPLES_PER_BIT-1 it wraps to 0 and bit_cnt increments.
  - At bit_cnt==7 with samp_cnt wrap, the byte is done:
    - If hold_full, load hold into shreg on the same edge (seamless, no gap sample).
    - Otherwise shreg_valid<=0.
- Simultaneous byte-done and byte accept: hold is empty, so shreg_valid<=0 and hold_full<=1. The normal load follows next cycle, giving a 1-cycle data_rdy gap.
- mod_en=0: counters and shreg freeze mid-bit; mod_valid=0; mod_out holds last value. Resumes at the same position when mod_en returns.
- sine_valid while mod_en=1 and shreg_valid=0: mod_out<=0, mod_valid<=1, underrun<=1 (sticky until rst).
- sine_valid while mod_en=0: ignored, no output.
- mod_valid and sym_start are single-cycle pulses.

Test Plan:
- Reset: hold rst 2 cycles mid-stream -> all outputs 0, byte_ready=1, data_rdy=0, underrun=0. Byte in flight discarded.
- Single byte 0xA5, mod_en=1, sine_in constant +100 every cycle:
  - 128 mod_valid pulses in per-bit groups of 16: +100 for bits 1,0,1,0,0,1,0,1 → -100 for 0s.
  - sym_start on samples 0,16,...,112.
  - data_rdy falls after sample 128.
- Back-to-back 0xFF then 0x00 (second byte presented during first):
  - 256 contiguous samples, no gap, sign flips exactly at sample 128.
  - byte_ready low while hold full.
- Saturation: bit 0 with sine_in=-2048 (SAMPLE_W=12) -> mod_out=+2047. Bit 0 with sine_in=+5 -> -5.
- mod_en drop at sample 7 of bit 3 for 20 cycles:
  - No mod_valid during the drop.
  - After re-enable, samples continue at sample 8 of bit 3, total still 128.
- Underrun: byte source stalls after one byte, mod_en held 1, sine_valid continues:
  - mod_out=0, mod_valid pulses, underrun=1 and stays 1 after a new byte arrives.
  - New byte modulates normally.

Source files
------------

// File: rtl/bpsk_bit_modulator.sv
// bpsk_bit_modulator: double-buffered byte serialiser that applies a +/-1 BPSK sign to sine samples,
// one bit per SAMPLES_PER_BIT samples, MSB first.
module bpsk_bit_modulator #(
   parameter int SAMPLE_W        = 12,
   parameter int SAMPLES_PER_BIT = 16,
   parameter int CNT_W           = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mod_en,
   input  logic                       sine_valid,
   input  logic signed [SAMPLE_W-1:0] sine_in,
   input  logic [7:0]                 byte_in,
   input  logic                       byte_valid,
   output logic                       byte_ready,
   output logic                       data_rdy,
   output logic signed [SAMPLE_W-1:0] mod_out,
   output logic                       mod_valid,
   output logic                       bit_out,
   output logic                       sym_start,
   output logic                       underrun
);
   localparam logic signed [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
   localparam logic signed [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam logic [CNT_W-1:0] SAMP_LAST = CNT_W'(SAMPLES_PER_BIT - 1);
   logic [7:0] hold, shreg;
   logic hold_full, shreg_valid;
   logic [2:0] bit_cnt;
   logic [CNT_W-1:0] samp_cnt;
   logic accept, load, modulate, starve, samp_wrap, byte_done, cur_bit;
   logic signed [SAMPLE_W-1:0] neg_in;
   always_comb begin
      byte_ready = ~hold_full;
      data_rdy   = shreg_valid;
      accept     = byte_valid & ~hold_full;
      modulate   = mod_en & sine_valid & shreg_valid;
      starve     = mod_en & sine_valid & ~shreg_valid;
      samp_wrap  = samp_cnt == SAMP_LAST;
      byte_done  = modulate & samp_wrap & (bit_cnt == 3'd7);
      load       = hold_full & (~shreg_valid | byte_done);
      cur_bit    = shreg[3'd7 - bit_cnt];
      neg_in     = (sine_in == S_MIN) ? S_MAX : -sine_in;
   end
   // load overrides the counter advance so a byte boundary reloads seamlessly
   always_ff @(posedge clk) begin
      if (rst) begin
         hold        <= '0;
         hold_full   <= 1'b0;
         shreg       <= '0;
         shreg_valid <= 1'b0;
         bit_cnt     <= '0;
         samp_cnt    <= '0;
         mod_out     <= '0;
         mod_valid   <= 1'b0;
         bit_out     <= 1'b0;
         sym_start   <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         mod_valid <= modulate | starve;
         sym_start <= modulate & (samp_cnt == '0);
         hold_full <= accept | (hold_full & ~load);
         if (accept) hold <= byte_in;
         if (modulate) begin
            samp_cnt <= samp_wrap ? '0 : samp_cnt + 1'b1;
            if (samp_wrap) bit_cnt <= bit_cnt + 3'd1;
            mod_out <= cur_bit ? sine_in : neg_in;
            bit_out <= cur_bit;
         end
         if (starve) begin
            mod_out  <= '0;
            underrun <= 1'b1;
         end
         if (byte_done) shreg_valid <= 1'b0;
         if (load) begin
            shreg       <= hold;
            shreg_valid <= 1'b1;
            bit_cnt     <= '0;
            samp_cnt    <= '0;
         end
      end
   end
endmodule
